// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store definitions: funct3 width codes, LSU state encoding,
// default memory index width and the request legality rule.
package riscv_pkg;

  localparam int LSU_WORD_IDX_W = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    LSU_IDLE   = 3'd0,
    LSU_LOAD   = 3'd1,
    LSU_RMW_RD = 3'd2,
    LSU_WRITE  = 3'd3,
    LSU_RESP   = 3'd4
  } lsu_state_e;

  // Width code must exist for the direction and the address must be naturally aligned.
  function automatic logic lsu_legal(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] lane);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~lane[0];
      F3_W:    ok = (lane == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~lane[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling for a 32-bit word: extended load extraction and
// sub-word store merge. Purely combinational.
module lsu_lane_align
  import riscv_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = word_i >> {lane_i, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = lane_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_B:    load_o = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_o = {24'd0, byte_v};
      F3_H:    load_o = {{16{half_v[15]}}, half_v};
      F3_HU:   load_o = {16'd0, half_v};
      default: load_o = word_i;
    endcase

    merge_o = word_i;
    case (funct3_i)
      F3_B: merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H: begin
        if (lane_i[1]) merge_o[31:16] = wdata_i[15:0];
        else           merge_o[15:0]  = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-indexed memory with combinational read and
// clocked write. Optional upper-address range check: LSU_RANGE_CHECK_EN.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int WORD_IDX_W = LSU_WORD_IDX_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd,
  output logic [2:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising CLK edge where valid and ready
  // are both high; valid and its payload stay stable until that edge.

  lsu_state_e  state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic        in_range;
  logic        req_legal;
  logic [31:0] align_word;
  logic [31:0] load_data;
  logic [31:0] merged;

`ifdef LSU_RANGE_CHECK_EN
  assign in_range = (req_addr >> (WORD_IDX_W + 2)) == 32'd0;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:WORD_IDX_W+2];
  assign in_range = 1'b1;
`endif

  assign req_legal = lsu_legal(req_we, req_funct3, req_addr[1:0]) & in_range;

  // The merge register only feeds the aligner while writing; otherwise it sees live read data.
  assign align_word = (state_q == LSU_WRITE) ? merge_q : mem_rd;

  lsu_lane_align u_align (
    .word_i   (align_word),
    .wdata_i  (wdata_q),
    .lane_i   (lane_q),
    .funct3_i (f3_q),
    .load_o   (load_data),
    .merge_o  (merged)
  );

  always_comb begin
    state_d    = state_q;
    f3_d       = f3_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
    merge_d    = merge_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          f3_d    = req_funct3;
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata;
          rdata_d = 32'd0;
          err_d   = ~req_legal;
          if (!req_legal) begin
            state_d = LSU_RESP;
          end else begin
            mem_addr_d = {{(32-WORD_IDX_W){1'b0}}, req_addr[WORD_IDX_W+1:2]};
            if (!req_we)                 state_d = LSU_LOAD;
            else if (req_funct3 == F3_W) state_d = LSU_WRITE;
            else                         state_d = LSU_RMW_RD;
          end
        end
      end
      LSU_LOAD: begin
        rdata_d = load_data;
        state_d = LSU_RESP;
      end
      LSU_RMW_RD: begin
        merge_d = mem_rd;
        state_d = LSU_WRITE;
      end
      LSU_WRITE: state_d = LSU_RESP;
      LSU_RESP: begin
        if (resp_ready) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= LSU_IDLE;
      f3_q       <= 3'd0;
      lane_q     <= 2'd0;
      wdata_q    <= 32'd0;
      merge_q    <= 32'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      mem_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      f3_q       <= f3_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      merge_q    <= merge_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign req_ready  = (state_q == LSU_IDLE);
  assign resp_valid = (state_q == LSU_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_we     = (state_q == LSU_WRITE);
  assign mem_wd     = mem_we ? merged : 32'd0;
  assign mem_addr   = mem_addr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written multi-cycle
// sequences and randomized traffic checked against a behavioural memory model.
module tb_load_store_unit;
  import riscv_pkg::*;

  localparam int IW    = 8;
  localparam int DEPTH = 256;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_we;
  logic [2:0]  dbg_state;

  always #5 CLK = ~CLK;

  load_store_unit #(.WORD_IDX_W(IW)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
    .dbg_state(dbg_state)
  );

  // Environment memory: combinational read, clocked write.
  logic [31:0] tb_mem [DEPTH];
  logic        unused_tb;
  assign unused_tb = ^mem_addr[31:IW];
  assign mem_rd = tb_mem[mem_addr[IW-1:0]];
  always @(posedge CLK) if (mem_we) tb_mem[mem_addr[IW-1:0]] <= mem_wd;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural memory image and the load/store rules.
  logic [31:0] gold_mem [DEPTH];

  function automatic void ref_access(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     output logic [31:0] rdata, output logic err,
                                     output int lat, output logic [31:0] wr_word);
    int unsigned idx, sh, sh16, v;
    logic [31:0] w;
    logic ok;
    idx  = (addr / 4) % DEPTH;
    sh   = (addr % 4) * 8;
    sh16 = ((addr % 4) / 2) * 16;
    w    = gold_mem[idx];
    if (we) ok = (f3 == 0) || (f3 == 1 && addr % 2 == 0) || (f3 == 2 && addr % 4 == 0);
    else    ok = (f3 == 0) || (f3 == 4) || ((f3 == 1 || f3 == 5) && addr % 2 == 0) ||
                 (f3 == 2 && addr % 4 == 0);
`ifdef LSU_RANGE_CHECK_EN
    if (addr >= 4 * DEPTH) ok = 1'b0;
`endif
    rdata = 0; err = !ok; wr_word = 0; lat = 1;
    if (ok && !we) begin
      lat = 2;
      case (f3)
        0: begin v = (w >> sh) & 255;     rdata = (v >= 128)   ? v + 32'hFFFFFF00 : v; end
        4: begin v = (w >> sh) & 255;     rdata = v; end
        1: begin v = (w >> sh16) & 65535; rdata = (v >= 32768) ? v + 32'hFFFF0000 : v; end
        5: begin v = (w >> sh16) & 65535; rdata = v; end
        default: rdata = w;
      endcase
    end else if (ok && we) begin
      case (f3)
        0: begin w = (w & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh); lat = 3; end
        1: begin w = (w & ~(32'hFFFF << sh16)) | ((wdata & 32'hFFFF) << sh16); lat = 3; end
        default: begin w = wdata; lat = 2; end
      endcase
      gold_mem[idx] = w;
      wr_word = w;
    end
  endfunction

  // Driver: issue one request, then count cycles after the acceptance edge until resp_valid.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                        output int lat, output int pulses, output int pulse_at,
                        output logic [31:0] wd_seen);
    int n = 0;
    @(negedge CLK);
    while (!req_ready && n < 20) begin @(negedge CLK); n++; end
    if (!req_ready) check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    req_addr = $urandom(); req_wdata = $urandom();
    lat = 0; pulses = 0; pulse_at = 0; wd_seen = 0; rdata = 0; err = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (mem_we) begin pulses++; pulse_at = c; wd_seen = mem_wd; end
      if (resp_valid) begin lat = c; rdata = resp_rdata; err = resp_err; break; end
    end
    if (lat == 0) check("resp_timeout", 32'd0, 32'd1);
    resp_ready = 1'b1;
    @(posedge CLK);
    #1 resp_ready = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_pulses;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, wr_word, m_rd;
    logic        er, m_er;
    int          lat, pulses, pulse_at, m_lat;
    logic [31:0] wd_seen, init_w;

    vecs.push_back('{0, 3'b000, 32'h15,  32'h0,        32'hFFFFFFAA, 0, 2, 0, 32'h0});
    vecs.push_back('{0, 3'b100, 32'h15,  32'h0,        32'h000000AA, 0, 2, 0, 32'h0});
    vecs.push_back('{1, 3'b000, 32'h16,  32'h12,       32'h0,        0, 3, 1, 32'h8812AABB});
    vecs.push_back('{0, 3'b010, 32'h14,  32'h0,        32'h8812AABB, 0, 2, 0, 32'h0});
    vecs.push_back('{0, 3'b001, 32'h16,  32'h0,        32'hFFFF8812, 0, 2, 0, 32'h0});
    vecs.push_back('{0, 3'b101, 32'h14,  32'h0,        32'h0000AABB, 0, 2, 0, 32'h0});
    vecs.push_back('{1, 3'b001, 32'h21,  32'h5555,     32'h0,        1, 1, 0, 32'h0});
    vecs.push_back('{0, 3'b011, 32'h14,  32'h0,        32'h0,        1, 1, 0, 32'h0});
    vecs.push_back('{1, 3'b100, 32'h14,  32'h77,       32'h0,        1, 1, 0, 32'h0});
    vecs.push_back('{0, 3'b010, 32'h15,  32'h0,        32'h0,        1, 1, 0, 32'h0});
    vecs.push_back('{0, 3'b101, 32'h15,  32'h0,        32'h0,        1, 1, 0, 32'h0});
    vecs.push_back('{1, 3'b010, 32'h00,  32'hCAFEF00D, 32'h0,        0, 2, 1, 32'hCAFEF00D});
`ifdef LSU_RANGE_CHECK_EN
    vecs.push_back('{0, 3'b010, 32'h400, 32'h0,        32'h0,        1, 1, 0, 32'h0});
`else
    vecs.push_back('{0, 3'b010, 32'h400, 32'h0,        32'hCAFEF00D, 0, 2, 0, 32'h0});
`endif
    vecs.push_back('{0, 3'b000, 32'h3FF, 32'h0,        32'h0000007F, 0, 2, 0, 32'h0});
    vecs.push_back('{0, 3'b000, 32'h3FE, 32'h0,        32'h00000000, 0, 2, 0, 32'h0});
    vecs.push_back('{0, 3'b100, 32'h3FD, 32'h0,        32'h000000FF, 0, 2, 0, 32'h0});
    vecs.push_back('{0, 3'b000, 32'h3FD, 32'h0,        32'hFFFFFFFF, 0, 2, 0, 32'h0});
    vecs.push_back('{1, 3'b001, 32'h3FE, 32'hABCD1234, 32'h0,        0, 3, 1, 32'h1234FF01});
    vecs.push_back('{0, 3'b101, 32'h3FE, 32'h0,        32'h00001234, 0, 2, 0, 32'h0});
    vecs.push_back('{0, 3'b001, 32'h3FC, 32'h0,        32'hFFFFFF01, 0, 2, 0, 32'h0});

    // Clock/reset and memory image
    RST = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0)        init_w = 32'h11223344;
      else if (i == 5)   init_w = 32'h8899AABB;
      else if (i == 255) init_w = 32'h7F00FF01;
      else               init_w = $urandom();
      tb_mem[i]   <= init_w;
      gold_mem[i]  = init_w;
    end
    #1;
    check("rst_req_ready",  {31'd0, req_ready},  32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err",   {31'd0, resp_err},   32'd0);
    check("rst_resp_rdata", resp_rdata,          32'd0);
    check("rst_mem_we",     {31'd0, mem_we},     32'd0);
    check("rst_mem_addr",   mem_addr,            32'd0);
    check("rst_mem_wd",     mem_wd,              32'd0);
    check("rst_state",      {29'd0, dbg_state},  {29'd0, LSU_IDLE});
    @(negedge CLK); @(negedge CLK);
    RST = 1'b1;

    // Directed vector table
    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
             rd, er, lat, pulses, pulse_at, wd_seen);
      ref_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                 m_rd, m_er, m_lat, wr_word);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_we_pulses", i), 32'(pulses), 32'(vecs[i].exp_pulses));
      if (vecs[i].exp_pulses == 1) begin
        check($sformatf("vec%0d_mem_wd", i), wd_seen, vecs[i].exp_wd);
        check($sformatf("vec%0d_we_cycle", i), 32'(pulse_at), 32'(vecs[i].exp_lat - 1));
      end
    end

    // Response back-pressure: held response stays stable and blocks new requests.
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h14;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 10 && !resp_valid; c++) @(negedge CLK);
    check("hold_resp_arrives", {31'd0, resp_valid}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h14; req_wdata = 32'hDEADBEEF;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_resp_rdata", resp_rdata, gold_mem[5]);
      check("hold_req_ready",  {31'd0, req_ready}, 32'd0);
      check("hold_mem_we",     {31'd0, mem_we},    32'd0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge CLK);
    #1 resp_ready = 1'b0;
    @(negedge CLK);
    check("hold_release_valid", {31'd0, resp_valid}, 32'd0);
    check("hold_release_ready", {31'd0, req_ready},  32'd1);
    check("hold_no_write",      tb_mem[5],           gold_mem[5]);

    // Reset asserted while an SB is in its read phase.
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h31; req_wdata = 32'h5A;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(negedge CLK);
    check("rmw_state_before_rst", {29'd0, dbg_state}, {29'd0, LSU_RMW_RD});
    RST = 1'b0;
    #1;
    check("rst_mid_mem_we", {31'd0, mem_we}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("rst_hold_mem_we", {31'd0, mem_we}, 32'd0);
    end
    RST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("post_rst_mem_we", {31'd0, mem_we}, 32'd0);
    end
    check("post_rst_req_ready",  {31'd0, req_ready},  32'd1);
    check("post_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("post_rst_state",      {29'd0, dbg_state},  {29'd0, LSU_IDLE});
    check("post_rst_mem_word",   tb_mem[12],          gold_mem[12]);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_addr, r_wd;
      r_we   = 1'($urandom_range(0, 1));
      r_f3   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                           : (r_we ? 3'($urandom_range(0, 2))
                                                   : 3'($urandom_range(0, 5)));
      r_addr = 32'($urandom_range(0, 4 * DEPTH - 1));
      if ($urandom_range(0, 2) != 0) r_addr[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) r_addr = r_addr | ($urandom() << 10);
      r_wd   = $urandom();
      do_req(r_we, r_f3, r_addr, r_wd, rd, er, lat, pulses, pulse_at, wd_seen);
      ref_access(r_we, r_f3, r_addr, r_wd, m_rd, m_er, m_lat, wr_word);
      check("rand_rdata", rd, m_rd);
      check("rand_err", {31'd0, er}, {31'd0, m_er});
      check("rand_lat", 32'(lat), 32'(m_lat));
      check("rand_we_pulses", 32'(pulses), (r_we && !m_er) ? 32'd1 : 32'd0);
      if (r_we && !m_er) check("rand_mem_wd", wd_seen, wr_word);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the single-cycle-read / clocked-write data memory port.
- Accepts byte-addressed load/store requests from the RISC-V execute stage over a valid/ready handshake.
- Drives the word-indexed memory port; sub-word stores are done as read-modify-write.
- Returns sign/zero-extended load data and an error flag over a valid/ready response channel.

Parameters:
- WORD_IDX_W, 8, width of the memory word index; memory depth is 2**WORD_IDX_W words.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned / illegal funct3 (/ out of range)
- mem_addr  out  32  word index {zeros, req_addr[WORD_IDX_W+1:2]}
- mem_wd  out  32  word written to memory
- mem_we  out  1  memory write enable, sampled at posedge CLK
- mem_rd  in  32  combinational read data for mem_addr

Behaviour:
- Reset (RST low, asynchronous): state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_we=0; mem_addr=0; mem_wd=0.
- Reset mid-operation: the request is dropped and no write is issued after reset asserts.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP. Next state is registered; outputs are decoded from registered state and latched fields.
- IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata, then go to:
  - RESP with err=1 if the request is illegal;
  - LOAD for a legal load;
  - WRITE for SW;
  - RMW_RD for SB/SH.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is an error.
- Misalignment is an error: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. An errored request never asserts mem_we.
- LOAD (1 cycle): mem_addr driven. At the clock edge, the selected byte/half of mem_rd is captured, extended and placed in resp_rdata; next state RESP.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- RMW_RD (1 cycle): mem_addr driven; mem_rd is captured into the merge register; next state WRITE.
- WRITE (1 cycle): mem_we=1 and mem_wd = merged word.
  - SB replaces lane addr[1:0] with wdata[7:0].
  - SH replaces half addr[1] with wdata[15:0].
  - SW writes wdata unchanged.
  - Next state RESP.
- RESP: resp_valid=1, held with stable data until resp_ready=1 at a clock edge; then go to IDLE. req_ready=0 in every state except IDLE.
- Latency from the acceptance edge to resp_valid: load 2 cycles, SW 2, SB/SH 3, error 1.
- Outside LOAD/RMW_RD/WRITE: mem_we=0 and mem_addr holds its last value.
- Address wrap: bits above WORD_IDX_W+1 are ignored, so the index wraps modulo the memory depth.

Optional Feature:
- Macro LSU_RANGE_CHECK_EN.
- Defined: req_addr[31:WORD_IDX_W+2] != 0 is an error, handled like misalignment (RESP, err=1, no memory access).
- Undefined: upper address bits are ignored and the address wraps.

Decomposition:
- Shared package riscv_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state encoding (LSU_IDLE..LSU_RESP, 3 bits);
  - WORD_IDX_W default.
- One sub-module, lsu_lane_align: combinational; takes word, addr[1:0] and funct3 and produces load extraction plus store merge. Reused by any future cache.

Test Plan:
- Memory word 5 = 0x8899AABB; LB at addr 0x15 → resp_rdata=0xFFFFFFAA, err=0, resp_valid 2 cycles after acceptance; LBU at the same address → 0x000000AA.
- SB wdata=0x12 at addr 0x16 over word 0x8899AABB → mem_we pulses once in the 3rd cycle with mem_wd=0x8812AABB; a following LW at 0x14 returns 0x8812AABB.
- SH at addr 0x21 → resp_err=1 after 1 cycle, mem_we never asserted; funct3=011 load → err=1.
- Hold resp_ready=0 for 5 cycles → resp_valid and resp_rdata stay stable, req_ready=0, and a new req_valid is not accepted.
- Assert RST during RMW_RD of an SB → no mem_we pulse; after release: IDLE, req_ready=1, resp_valid=0.
- Address 0x400 with LSU_RANGE_CHECK_EN → err=1; without it → accesses word 0.
